// File: rtl/snn_param_loader.sv
// ---------------------------------------------------------------------------
// snn_param_loader
//   Fills the snn_core weight RAM (F*N words) and then the threshold table
//   (N words) from a valid/ready word stream. Weight word k lands at linear
//   index k = f*N + n, the same indexing the rb_addr/rb_data readback uses,
//   so a readback dump can be streamed back in unchanged. The core is held
//   idle (o_core_hold) for the whole load.
//
// Optional feature macro: SNN_LOADER_CKSUM_EN
//   defined   : o_cksum is the 16-bit wrap-around sum of all written words.
//   undefined : no adder is built; o_cksum is tied to zero.
//
// Ports
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_start             1-cycle pulse, starts a load; only honoured in IDLE
//   i_s_valid/o_s_ready stream handshake, i_s_data word, i_s_last end marker
//   o_w_we/addr/data    weight RAM write port (1-cycle registered latency)
//   o_vth_we/addr/data  threshold table write port (same latency)
//   o_core_hold         1 in LOAD_W, LOAD_V and FIN
//   o_done              1-cycle pulse on clean completion (FIN state)
//   o_err               sticky framing error, cleared by an accepted start
//   o_cksum             running word checksum (see macro above)
//   o_dbg_state         current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where i_s_valid && o_s_ready.
// o_s_ready depends only on the FSM state, never on i_s_valid.
// ---------------------------------------------------------------------------
module snn_param_loader #(
    parameter int F  = 48,
    parameter int N  = 96,
    parameter int AW = $clog2(F*N),
    parameter int VW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_s_valid,
    input  logic [15:0]   i_s_data,
    input  logic          i_s_last,
    output logic          o_s_ready,
    output logic          o_w_we,
    output logic [AW-1:0] o_w_addr,
    output logic [15:0]   o_w_data,
    output logic          o_vth_we,
    output logic [VW-1:0] o_vth_addr,
    output logic [15:0]   o_vth_data,
    output logic          o_core_hold,
    output logic          o_done,
    output logic          o_err,
    output logic [15:0]   o_cksum,
    output logic [2:0]    o_dbg_state
);

    localparam int CW = (AW > VW) ? AW : VW;
    localparam logic [CW-1:0] LP_W_LAST = CW'(F*N - 1);
    localparam logic [CW-1:0] LP_V_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_V = 3'd2,
        S_FIN    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_w_we;
    logic [AW-1:0] r_w_addr;
    logic [15:0]   r_w_data;
    logic          r_vth_we;
    logic [VW-1:0] r_vth_addr;
    logic [15:0]   r_vth_data;
    logic          r_err;

    logic w_accept;
    logic w_final_v;
    logic w_drop;
    logic w_write;

    assign w_accept  = i_s_valid && o_s_ready;
    // Only the very last threshold word may carry s_last; on any other word
    // s_last is a framing fault and that word is discarded.
    assign w_final_v = (r_state == S_LOAD_V) && (r_cnt == LP_V_LAST);
    assign w_drop    = w_accept && i_s_last && !w_final_v;
    assign w_write   = w_accept && !w_drop;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_LOAD_W;
            S_LOAD_W: if (w_accept) begin
                          if (i_s_last)                w_state_nxt = S_ERR;
                          else if (r_cnt == LP_W_LAST) w_state_nxt = S_LOAD_V;
                      end
            S_LOAD_V: if (w_accept) begin
                          if (w_final_v) w_state_nxt = i_s_last ? S_FIN : S_ERR;
                          else if (i_s_last) w_state_nxt = S_ERR;
                      end
            S_FIN:    w_state_nxt = S_IDLE;
            S_ERR:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic (state-decoded)
    always_comb begin
        o_s_ready   = 1'b0;
        o_core_hold = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_LOAD_W, S_LOAD_V: begin
                o_s_ready   = 1'b1;
                o_core_hold = 1'b1;
            end
            S_FIN: begin
                o_core_hold = 1'b1;
                o_done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: counter, registered write ports, error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_w_we     <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_vth_we   <= 1'b0;
            r_vth_addr <= '0;
            r_vth_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_w_we   <= 1'b0;
            r_vth_we <= 1'b0;
            if (r_state == S_IDLE && i_start) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end
            if (w_write && r_state == S_LOAD_W) begin
                r_w_we   <= 1'b1;
                r_w_addr <= r_cnt[AW-1:0];
                r_w_data <= i_s_data;
                // The counter is reused for the threshold phase.
                r_cnt    <= (r_cnt == LP_W_LAST) ? '0 : r_cnt + CW'(1);
            end
            if (w_write && r_state == S_LOAD_V) begin
                r_vth_we   <= 1'b1;
                r_vth_addr <= r_cnt[VW-1:0];
                r_vth_data <= i_s_data;
                r_cnt      <= r_cnt + CW'(1);
            end
            if (w_state_nxt == S_ERR) r_err <= 1'b1;
        end
    end

`ifdef SNN_LOADER_CKSUM_EN
    logic [15:0] r_cksum;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                             r_cksum <= '0;
        else if (r_state == S_IDLE && i_start) r_cksum <= '0;
        else if (w_write)                      r_cksum <= r_cksum + i_s_data;
    end
    assign o_cksum = r_cksum;
`else
    assign o_cksum = 16'h0000;
`endif

    assign o_w_we      = r_w_we;
    assign o_w_addr    = r_w_addr;
    assign o_w_data    = r_w_data;
    assign o_vth_we    = r_vth_we;
    assign o_vth_addr  = r_vth_addr;
    assign o_vth_data  = r_vth_data;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule
